// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
//   Shared types for the RV32 pipeline.
//   - Inter-stage payload structs.
//   - Bubble constants that callers pass to rv32_pipe_stage as BUBBLE.
//   - pipe_state_t, which is the state of the generic pipeline register.
//   - PIPE_WIDTH_* localparams, used to size each stage instance.
//   No ports (package).
// -----------------------------------------------------------------------------
package rv32_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_ONE   = 2'd1,
      PS_TWO   = 2'd2
   } pipe_state_t;

   // addi x0, x0, 0: the canonical RV32 NOP
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
   } id_ex_t;

   typedef struct packed {
      logic [31:0] alu_res;
      logic [31:0] rs2_val;
      logic [4:0]  rd;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] wb_data;
      logic [4:0]  rd;
      logic        reg_write;
   } mem_wb_t;

   localparam int PIPE_WIDTH_IF_ID  = $bits(if_id_t);
   localparam int PIPE_WIDTH_ID_EX  = $bits(id_ex_t);
   localparam int PIPE_WIDTH_EX_MEM = $bits(ex_mem_t);
   localparam int PIPE_WIDTH_MEM_WB = $bits(mem_wb_t);

   // Bubbles never write back or touch memory. IF/ID carries a NOP so that
   // decode of an empty slot is harmless.
   localparam if_id_t  IF_ID_BUBBLE  = '{pc: 32'h0000_0000, instr: NOP_INSTR};
   localparam id_ex_t  ID_EX_BUBBLE  = '0;
   localparam ex_mem_t EX_MEM_BUBBLE = '0;
   localparam mem_wb_t MEM_WB_BUBBLE = '0;

   // Number of held entries in each state.
   function automatic logic [1:0] pipe_occupancy(input pipe_state_t st);
      logic [1:0] n;
      case (st)
         PS_EMPTY: n = 2'd0;
         PS_ONE:   n = 2'd1;
         PS_TWO:   n = 2'd2;
         default:  n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/rv32_pipe_stage_chk.sv
// -----------------------------------------------------------------------------
// rv32_pipe_stage_chk
//   Checks protocol invariants of one rv32_pipe_stage instance.
//   Ports (all inputs):
//     clk, rst           clock and synchronous reset of the observed stage
//     in_ready           observed stage in_ready
//     out_valid          observed stage out_valid
//     out_data [WIDTH]   observed stage out_data
//     occupancy [2]      observed stage occupancy
//   The checks are armed only after the first reset has been seen.
// -----------------------------------------------------------------------------
module rv32_pipe_stage_chk #(
   parameter int               WIDTH  = 32,
   parameter logic [WIDTH-1:0] BUBBLE = '0,
   parameter int               SKID   = 1
) (
   input logic             clk,
   input logic             rst,
   input logic             in_ready,
   input logic             out_valid,
   input logic [WIDTH-1:0] out_data,
   input logic [1:0]       occupancy
);

   logic armed_r;

   // Remember that the observed stage has been reset at least once.
   always_ff @(posedge clk) begin
      if (rst) begin
         armed_r <= 1'b1;
      end else begin
         armed_r <= armed_r;
      end
   end

   // Invariants sampled on every rising edge outside reset.
   always @(posedge clk) begin
      if (armed_r && !rst) begin
         assert (occupancy <= 2'd2)
            else $error("rv32_pipe_stage: occupancy %0d exceeds 2", occupancy);
         assert (out_valid || (out_data == BUBBLE))
            else $error("rv32_pipe_stage: out_data is not BUBBLE while out_valid=0");
         if (SKID != 0) begin
            assert (in_ready || (occupancy == 2'd2))
               else $error("rv32_pipe_stage: in_ready=0 outside the two-entry state");
         end else begin
            assert (occupancy <= 2'd1)
               else $error("rv32_pipe_stage: occupancy %0d without skid entry", occupancy);
         end
      end
   end

endmodule

// File: rtl/rv32_pipe_stage.sv
// -----------------------------------------------------------------------------
// rv32_pipe_stage
//   This is a generic valid/ready pipeline register for the RV32 stages.
//   It supports back-pressure, flush and bubble substitution.
//   When SKID=1, it holds two entries (main + skid), and in_ready comes
//   straight from a flop.
//   When SKID=0, it holds a single entry, and in_ready is combinational.
//   Ports:
//     clk        in   1      clock, rising edge
//     rst        in   1      synchronous reset, active-high, wins over flush
//     in_valid   in   1      upstream payload valid
//     in_ready   out  1      stage accepts this cycle
//     in_data    in   WIDTH  upstream payload
//     flush      in   1      drop all held entries and any same-cycle accept
//     out_valid  out  1      downstream payload valid
//     out_ready  in   1      downstream accepts (0 = stall)
//     out_data   out  WIDTH  downstream payload, BUBBLE whenever out_valid=0
//     occupancy  out  2      entries held after the last edge
// -----------------------------------------------------------------------------
module rv32_pipe_stage
   import rv32_pkg::*;
#(
   parameter int               WIDTH  = 32,
   parameter logic [WIDTH-1:0] BUBBLE = '0,
   parameter int               SKID   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   pipe_state_t      state_r, state_n;
   logic [WIDTH-1:0] main_r, main_n;
   logic [WIDTH-1:0] skid_r, skid_n;
   logic             out_valid_r;
   logic [1:0]       occ_r;
   logic             acc_s, drn_s;

   assign acc_s = in_valid & in_ready;
   assign drn_s = out_valid_r & out_ready;

   // Next-state and next-payload selection. main_r is always the head beat,
   // or BUBBLE when empty, so it drives out_data directly.
   always_comb begin
      state_n = state_r;
      main_n  = main_r;
      skid_n  = skid_r;
      if (flush) begin
         // A drain in this cycle has already completed downstream, and an
         // accept in this cycle is discarded.
         state_n = PS_EMPTY;
         main_n  = BUBBLE;
         skid_n  = BUBBLE;
      end else begin
         case (state_r)
            PS_EMPTY: begin
               if (acc_s) begin
                  state_n = PS_ONE;
                  main_n  = in_data;
               end else begin
                  state_n = PS_EMPTY;
               end
            end
            PS_ONE: begin
               if (acc_s && drn_s) begin
                  main_n = in_data;
               end else if (acc_s) begin
                  // This path is reachable only with SKID=1. Without a skid
                  // entry, in_ready is low whenever ONE is stalled.
                  state_n = PS_TWO;
                  skid_n  = in_data;
               end else if (drn_s) begin
                  state_n = PS_EMPTY;
                  main_n  = BUBBLE;
               end else begin
                  state_n = PS_ONE;
               end
            end
            PS_TWO: begin
               if (drn_s) begin
                  state_n = PS_ONE;
                  main_n  = skid_r;
                  skid_n  = BUBBLE;
               end else begin
                  state_n = PS_TWO;
               end
            end
            default: begin
               state_n = PS_EMPTY;
               main_n  = BUBBLE;
               skid_n  = BUBBLE;
            end
         endcase
      end
   end

   // State, payload and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= PS_EMPTY;
         main_r      <= BUBBLE;
         skid_r      <= BUBBLE;
         out_valid_r <= 1'b0;
         occ_r       <= 2'd0;
      end else begin
         state_r     <= state_n;
         main_r      <= main_n;
         skid_r      <= skid_n;
         out_valid_r <= (state_n != PS_EMPTY);
         occ_r       <= pipe_occupancy(state_n);
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         logic in_ready_r;

         // Registered in_ready. It is low only while both entries are held.
         always_ff @(posedge clk) begin
            if (rst) begin
               in_ready_r <= 1'b1;
            end else begin
               in_ready_r <= (state_n != PS_TWO);
            end
         end

         assign in_ready = in_ready_r;
      end else begin : g_single
         assign in_ready = ~out_valid_r | out_ready;
      end
   endgenerate

   assign out_valid = out_valid_r;
   assign out_data  = main_r;
   assign occupancy = occ_r;

endmodule
